al_clock_core: RTL

Parametrised alarm-clock core: a BCD HH:MM:SS time-of-day counter with set-time and set-alarm modes, alarm compare, ring timeout and snooze. It sits between the 1 Hz tick generator and the 7-segment display driver. It takes over the time-keeping, time-setting and alarm duties of the top-level alarm controller, which currently only counts minutes.

---
 rtl/al_pkg.sv | 41 ++++
 rtl/al_hhmm_inc.sv | 40 ++++
 rtl/al_clock_core.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/al_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : al_pkg
//  Description : Shared encodings, BCD limits and a two-digit BCD increment
//                helper for the alarm-clock core.
//  Revision    : 1.0  initial release
// ============================================================================
package al_pkg;

    // Operating mode encodings; 2'b11 is not listed and behaves as RUN
    localparam logic [1:0] RUN       = 2'b00;
    localparam logic [1:0] SET_TIME  = 2'b01;
    localparam logic [1:0] SET_ALARM = 2'b10;

    // Alarm state machine encodings
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RINGING = 2'b01,
        SNOOZED = 2'b10
    } al_state_t;

    // Largest legal value of each two-digit BCD field
    localparam logic [7:0] c_HOUR_MAX = 8'h23;
    localparam logic [7:0] c_MIN_MAX  = 8'h59;
    localparam logic [7:0] c_SEC_MAX  = 8'h59;

    // Two-digit BCD increment that wraps to 00 after reaching i_max
    function automatic logic [7:0] bcd2_inc(input logic [7:0] i_v, input logic [7:0] i_max);
        logic [7:0] v_res;
        if (i_v == i_max) begin
            v_res = 8'h00;
        end else if (i_v[3:0] == 4'd9) begin
            v_res = {i_v[7:4] + 4'd1, 4'd0};
        end else begin
            v_res = {i_v[7:4], i_v[3:0] + 4'd1};
        end
        return v_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/al_hhmm_inc.sv
`default_nettype none
// ============================================================================
//  Module      : al_hhmm_inc
//  Description : Combinational BCD HH:MM increment. With neither flag set it
//                performs a full minute rollover (hour carry, 23:59 -> 00:00);
//                otherwise it bumps only the flagged field(s) without carry.
//  Revision    : 1.0  initial release
// ============================================================================
module al_hhmm_inc
    import al_pkg::*;
(
    input  logic [15:0] i_value,
    input  logic        i_inc_min_only,
    input  logic        i_inc_hour_only,
    output logic [15:0] o_value
);

    logic [7:0] w_hour_inc;
    logic [7:0] w_min_inc;
    logic       w_min_wrap;

    // Per-field increments and the carry out of the minute field
    always_comb begin
        w_hour_inc = bcd2_inc(i_value[15:8], c_HOUR_MAX);
        w_min_inc  = bcd2_inc(i_value[7:0], c_MIN_MAX);
        w_min_wrap = (i_value[7:0] == c_MIN_MAX);
    end

    // Select rollover behaviour or independent field setting
    always_comb begin
        if (!i_inc_min_only && !i_inc_hour_only) begin
            o_value = {(w_min_wrap ? w_hour_inc : i_value[15:8]), w_min_inc};
        end else begin
            o_value = {(i_inc_hour_only ? w_hour_inc : i_value[15:8]),
                       (i_inc_min_only  ? w_min_inc  : i_value[7:0])};
        end
    end

endmodule
`default_nettype wire

// File: rtl/al_clock_core.sv
`default_nettype none
// ============================================================================
//  Module      : al_clock_core
//  Description : BCD HH:MM:SS time-of-day counter with set-time / set-alarm
//                modes, alarm compare on minute rollover, ring timeout and
//                snooze. All outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module al_clock_core
    import al_pkg::*;
#(
    parameter int SECS_PER_MIN = 60,
    parameter int SNOOZE_MIN   = 10,
    parameter int RING_MIN     = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_sec,
    input  logic        fast_mode,
    input  logic [1:0]  mode,
    input  logic        inc_hour,
    input  logic        inc_min,
    input  logic        alarm_en,
    input  logic        snooze,
    output logic [15:0] time_bcd,
    output logic [7:0]  sec_bcd,
    output logic [15:0] alarm_bcd,
    output logic [15:0] disp_bcd,
    output logic        minute_pulse,
    output logic        alarm_ring
);

    localparam int c_PRE_W   = (SECS_PER_MIN > 1) ? $clog2(SECS_PER_MIN) : 1;
    localparam int c_CNT_MAX = (SNOOZE_MIN > RING_MIN) ? SNOOZE_MIN : RING_MIN;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_PRE_W-1:0] c_PRE_LAST  = c_PRE_W'(SECS_PER_MIN - 1);
    localparam logic [c_CNT_W-1:0] c_RING_LAST = c_CNT_W'(RING_MIN - 1);
    localparam logic [c_CNT_W-1:0] c_SNOOZE    = c_CNT_W'(SNOOZE_MIN);

    logic [15:0]        r_time;
    logic [7:0]         r_sec;
    logic [c_PRE_W-1:0] r_presc;
    logic [15:0]        r_alarm;
    logic [15:0]        r_disp;
    logic               r_minute_pulse;
    al_state_t          r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ring;

    logic               w_set_time;
    logic               w_set_alarm;
    logic [15:0]        w_time_inc;
    logic [15:0]        w_alarm_inc;
    logic [15:0]        w_time_next;
    logic [7:0]         w_sec_next;
    logic [c_PRE_W-1:0] w_presc_next;
    logic [15:0]        w_alarm_next;
    logic               w_rollover;
    logic               w_match;

    assign w_set_time  = (mode == SET_TIME);
    assign w_set_alarm = (mode == SET_ALARM);

    // Time incrementer: full rollover while counting, field set in set-time mode
    al_hhmm_inc u_time_inc (
        .i_value         (r_time),
        .i_inc_min_only  (w_set_time & inc_min),
        .i_inc_hour_only (w_set_time & inc_hour),
        .o_value         (w_time_inc)
    );

    // Alarm incrementer: only its field-set result is ever used
    al_hhmm_inc u_alarm_inc (
        .i_value         (r_alarm),
        .i_inc_min_only  (inc_min),
        .i_inc_hour_only (inc_hour),
        .o_value         (w_alarm_inc)
    );

    // Next-state datapath; set-time holds seconds at 00 so counting resumes cleanly
    always_comb begin
        w_time_next  = r_time;
        w_sec_next   = r_sec;
        w_presc_next = r_presc;
        w_alarm_next = r_alarm;
        w_rollover   = 1'b0;
        if (w_set_time) begin
            w_sec_next   = 8'h00;
            w_presc_next = '0;
            if (inc_min || inc_hour) begin
                w_time_next = w_time_inc;
            end
        end else if (fast_mode) begin
            w_sec_next   = 8'h00;
            w_presc_next = '0;
            if (tick_sec) begin
                w_rollover  = 1'b1;
                w_time_next = w_time_inc;
            end
        end else if (tick_sec) begin
            if (r_presc == c_PRE_LAST) begin
                w_rollover   = 1'b1;
                w_time_next  = w_time_inc;
                w_sec_next   = 8'h00;
                w_presc_next = '0;
            end else begin
                w_presc_next = r_presc + c_PRE_W'(1);
                w_sec_next   = bcd2_inc(r_sec, c_SEC_MAX);
            end
        end
        if (w_set_alarm && (inc_min || inc_hour)) begin
            w_alarm_next = w_alarm_inc;
        end
    end

    // Alarm match is evaluated only against the freshly rolled-over time
    assign w_match = w_rollover && alarm_en && (w_time_next == r_alarm);

    // Time, alarm and display registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_time         <= 16'h0000;
            r_sec          <= 8'h00;
            r_presc        <= '0;
            r_alarm        <= 16'h0000;
            r_disp         <= 16'h0000;
            r_minute_pulse <= 1'b0;
        end else begin
            r_time         <= w_time_next;
            r_sec          <= w_sec_next;
            r_presc        <= w_presc_next;
            r_alarm        <= w_alarm_next;
            r_disp         <= w_set_alarm ? w_alarm_next : w_time_next;
            r_minute_pulse <= w_rollover;
        end
    end

    // Alarm FSM; snooze wins over a coincident ring timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ring  <= 1'b0;
        end else if (!alarm_en) begin
            r_state <= IDLE;
            r_ring  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_match) begin
                        r_state <= RINGING;
                        r_cnt   <= '0;
                        r_ring  <= 1'b1;
                    end
                end
                RINGING: begin
                    if (snooze) begin
                        r_state <= SNOOZED;
                        r_cnt   <= c_SNOOZE;
                        r_ring  <= 1'b0;
                    end else if (w_rollover) begin
                        if (r_cnt == c_RING_LAST) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_ring  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                SNOOZED: begin
                    if (w_rollover) begin
                        if (r_cnt <= c_CNT_W'(1)) begin
                            r_state <= RINGING;
                            r_cnt   <= '0;
                            r_ring  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - c_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ring  <= 1'b0;
                end
            endcase
        end
    end

    assign time_bcd     = r_time;
    assign sec_bcd      = r_sec;
    assign alarm_bcd    = r_alarm;
    assign disp_bcd     = r_disp;
    assign minute_pulse = r_minute_pulse;
    assign alarm_ring   = r_ring;

endmodule
`default_nettype wire
